// File: rtl/rfalu_pkg.sv
// Shared types for the register-file/ALU pipeline: opcode enum, flag bundle and
// a shift-amount width helper.
package rfalu_pkg;

   typedef enum logic [2:0] {
      ADD_OP = 3'd0,
      SUB_OP = 3'd1,
      AND_OP = 3'd2,
      OR_OP  = 3'd3,
      XOR_OP = 3'd4,
      SLT_OP = 3'd5,
      SHL_OP = 3'd6,
      SHR_OP = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
   } alu_flags_t;

   // Number of low srcB bits that form a shift amount for a given data width.
   function automatic int shamt_width(input int data_w);
      return (data_w <= 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/reg_file_alu_pipe_alu_core.sv
// Combinational 8-operation ALU producing result plus zero/carry/negative flags.
module alu_core
   import rfalu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  alu_op_e           op_i,
   output logic [DATA_W-1:0] result_o,
   output alu_flags_t        flags_o
);

   localparam int SW = shamt_width(DATA_W);

   logic [DATA_W:0]   sum_s;
   logic [DATA_W-1:0] res_s;
   logic              carry_s;
   logic              lt_s;

   // Result and carry selection; SUB carry-out of a + ~b + 1 means "no borrow".
   always_comb begin
      sum_s   = '0;
      res_s   = '0;
      carry_s = 1'b0;
      lt_s    = ($signed(a_i) < $signed(b_i));
      case (op_i)
         ADD_OP: begin
            sum_s   = {1'b0, a_i} + {1'b0, b_i};
            res_s   = sum_s[DATA_W-1:0];
            carry_s = sum_s[DATA_W];
         end
         SUB_OP: begin
            sum_s   = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
            res_s   = sum_s[DATA_W-1:0];
            carry_s = sum_s[DATA_W];
         end
         AND_OP:  res_s = a_i & b_i;
         OR_OP:   res_s = a_i | b_i;
         XOR_OP:  res_s = a_i ^ b_i;
         SLT_OP:  res_s = {{(DATA_W-1){1'b0}}, lt_s};
         SHL_OP:  res_s = a_i << b_i[SW-1:0];
         SHR_OP:  res_s = a_i >> b_i[SW-1:0];
         default: res_s = '0;
      endcase
   end

   assign result_o         = res_s;
   assign flags_o.zero     = (res_s == '0);
   assign flags_o.carry    = carry_s;
   assign flags_o.negative = res_s[DATA_W-1];

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file/ALU datapath: operand read/immediate mux, then execute + writeback.
// Defining FORWARD_EN adds a bypass from the execute stage into the operand read.
module reg_file_alu_pipe
   import rfalu_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int OUT_REG  = NUM_REGS - 1
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        in_valid,
   input  logic [$clog2(NUM_REGS)-1:0] RA1,
   input  logic [$clog2(NUM_REGS)-1:0] RA2,
   input  logic [$clog2(NUM_REGS)-1:0] WA,
   input  logic [DATA_W-1:0]           immediate,
   input  logic [2:0]                  ALUControl,
   input  logic                        ALUSrc,
   input  logic                        write_enable,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           ALUResult,
   output logic                        Zero,
   output logic                        Carry,
   output logic                        Negative,
   output logic [DATA_W-1:0]           cpu_out
);

   localparam int            AW      = $clog2(NUM_REGS);
   localparam logic [AW-1:0] OUT_IDX = AW'(OUT_REG);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   alu_op_e           s1_op_q, s1_op_d;
   logic [AW-1:0]     s1_wa_q, s1_wa_d;
   logic              s1_we_q, s1_we_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   alu_flags_t        flags_q, flags_d;

   logic [DATA_W-1:0] alu_res_s;
   alu_flags_t        alu_flags_s;
   logic [DATA_W-1:0] rd1_s, rd2_s;
   logic              wb_en_s;

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .op_i     (s1_op_q),
      .result_o (alu_res_s),
      .flags_o  (alu_flags_s)
   );

   assign wb_en_s = s1_valid_q & s1_we_q;

   // Operand read; the bypass picks up the value being written back at this same edge.
   always_comb begin
`ifdef FORWARD_EN
      if (wb_en_s && (s1_wa_q == RA1)) begin
         rd1_s = alu_res_s;
      end else begin
         rd1_s = regs_q[RA1];
      end
      if (wb_en_s && (s1_wa_q == RA2)) begin
         rd2_s = alu_res_s;
      end else begin
         rd2_s = regs_q[RA2];
      end
`else
      rd1_s = regs_q[RA1];
      rd2_s = regs_q[RA2];
`endif
   end

   // Stage-1 next state: latch operands and control when an operation is presented.
   always_comb begin
      s1_valid_d = in_valid;
      if (in_valid) begin
         s1_a_d  = rd1_s;
         s1_b_d  = ALUSrc ? immediate : rd2_s;
         s1_op_d = alu_op_e'(ALUControl);
         s1_wa_d = WA;
         s1_we_d = write_enable;
      end else begin
         s1_a_d  = s1_a_q;
         s1_b_d  = s1_b_q;
         s1_op_d = s1_op_q;
         s1_wa_d = s1_wa_q;
         s1_we_d = s1_we_q;
      end
   end

   // Stage-2 next state: result and flags hold while no operation completes.
   always_comb begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
         result_d = alu_res_s;
         flags_d  = alu_flags_s;
      end else begin
         result_d = result_q;
         flags_d  = flags_q;
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= ADD_OP;
         s1_wa_q     <= '0;
         s1_we_q     <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         s1_wa_q     <= s1_wa_d;
         s1_we_q     <= s1_we_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   // Register file; reset wins over a writeback from an in-flight operation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en_s) begin
         regs_q[s1_wa_q] <= alu_res_s;
      end else begin
         regs_q[s1_wa_q] <= regs_q[s1_wa_q];
      end
   end

   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign Zero      = flags_q.zero;
   assign Carry     = flags_q.carry;
   assign Negative  = flags_q.negative;
   assign cpu_out   = regs_q[OUT_IDX];

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Self-checking bench for reg_file_alu_pipe: ALU vector table, hand-written pipeline
// sequences and a randomized run against an arithmetic reference model.
module tb_reg_file_alu_pipe;

   localparam int DW = 8;
   localparam int NR = 16;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          in_valid = 1'b0;
   logic [AW-1:0] RA1 = '0, RA2 = '0, WA = '0;
   logic [DW-1:0] immediate = '0;
   logic [2:0]    ALUControl = '0;
   logic          ALUSrc = 1'b0, write_enable = 1'b0;
   logic          out_valid, Zero, Carry, Negative;
   logic [DW-1:0] ALUResult, cpu_out;

   reg_file_alu_pipe #(.DATA_W(DW), .NUM_REGS(NR), .OUT_REG(NR - 1)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .RA1(RA1), .RA2(RA2), .WA(WA),
      .immediate(immediate), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
      .write_enable(write_enable), .out_valid(out_valid), .ALUResult(ALUResult),
      .Zero(Zero), .Carry(Carry), .Negative(Negative), .cpu_out(cpu_out)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int op; int a; int b; int res; int z; int c; int n;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // {result, zero, carry, negative} as one number
   function automatic int dut_pack();
      return int'({ALUResult, Zero, Carry, Negative});
   endfunction

   function automatic int pack(input int r, input int z, input int c, input int n);
      return (r << 3) | (z << 2) | (c << 1) | n;
   endfunction

   // Reference ALU from the opcode definitions, plain integer arithmetic.
   function automatic int alu_ref(input int op, input int a, input int b);
      int r, c, sa, sb;
      c = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      case (op)
         0: begin r = a + b; c = (r > 255) ? 1 : 0; end
         1: begin r = a - b + 256; c = (a >= b) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (sa < sb) ? 1 : 0;
         6: r = a << (b % 8);
         default: r = a >> (b % 8);
      endcase
      r = r % 256;
      return pack(r, (r == 0) ? 1 : 0, c, (r >= 128) ? 1 : 0);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      in_valid = 1'b0;
      tick();
      RST = 1'b0;
   endtask

   // Present one operation for one edge, then go idle.
   task automatic issue(input int op, input int ra1, input int ra2, input int wa,
                        input int imm, input bit src, input bit we);
      in_valid     = 1'b1;
      ALUControl   = 3'(op);
      RA1          = AW'(ra1);
      RA2          = AW'(ra2);
      WA           = AW'(wa);
      immediate    = DW'(imm);
      ALUSrc       = src;
      write_enable = we;
      tick();
      in_valid = 1'b0;
   endtask

   int m_regs[NR];
   int exp_pk, exp_ov, fwd_exp;
   bit pv, pwe, nv, nsrc, nwe;
   int pop, pa, pb, pwa, nop, nra1, nra2, nwa, nimm, a_old, b_old;

   initial begin
      vecs[0]  = '{0, 'hFF, 'h01, 'h00, 1, 1, 0};
      vecs[1]  = '{1, 'h05, 'h07, 'hFE, 0, 0, 1};
      vecs[2]  = '{1, 'h07, 'h07, 'h00, 1, 1, 0};
      vecs[3]  = '{2, 'hF0, 'h3C, 'h30, 0, 0, 0};
      vecs[4]  = '{3, 'h0F, 'h80, 'h8F, 0, 0, 1};
      vecs[5]  = '{4, 'hAA, 'hAA, 'h00, 1, 0, 0};
      vecs[6]  = '{5, 'h80, 'h01, 'h01, 0, 0, 0};
      vecs[7]  = '{5, 'h01, 'h80, 'h00, 1, 0, 0};
      vecs[8]  = '{6, 'h81, 'h01, 'h02, 0, 0, 0};
      vecs[9]  = '{7, 'h80, 'h07, 'h01, 0, 0, 0};
      vecs[10] = '{6, 'h01, 'h0B, 'h08, 0, 0, 0};
      vecs[11] = '{0, 'h7F, 'h01, 'h80, 0, 0, 1};
      vecs[12] = '{1, 'h00, 'h01, 'hFF, 0, 0, 1};

      // Reset state
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      check("reset out_valid", int'(out_valid), 0);
      check("reset result/flags", dut_pack(), 0);
      check("reset cpu_out", int'(cpu_out), 0);

      // Read of zeroed registers after reset
      issue(3, 0, 0, 1, 0, 1'b0, 1'b0);
      check("or r0 latency", int'(out_valid), 0);
      tick();
      check("or r0 out_valid", int'(out_valid), 1);
      check("or r0 result/flags", dut_pack(), pack(0, 1, 0, 0));
      check("or r0 cpu_out", int'(cpu_out), 0);
      tick();
      check("idle out_valid", int'(out_valid), 0);
      check("idle hold", dut_pack(), pack(0, 1, 0, 0));

      // Immediate loads then register-register add
      issue(0, 0, 0, 1, 'hFF, 1'b1, 1'b1);
      tick();
      issue(0, 0, 0, 2, 'h01, 1'b1, 1'b1);
      tick();
      issue(0, 1, 2, 3, 'h55, 1'b0, 1'b0);
      tick();
      check("r1+r2", dut_pack(), pack('h00, 1, 1, 0));

      // Vector table: load operand A into r1, then apply op with immediate B
      for (int i = 0; i < 13; i++) begin
         issue(0, 0, 0, 1, vecs[i].a, 1'b1, 1'b1);
         tick();
         issue(vecs[i].op, 1, 0, 6, vecs[i].b, 1'b1, 1'b0);
         tick();
         check($sformatf("vec%0d out_valid", i), int'(out_valid), 1);
         check($sformatf("vec%0d op%0d", i, vecs[i].op), dut_pack(),
               pack(vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].n));
      end

      // Back-to-back dependent operations
      do_reset();
      issue(0, 0, 0, 4, 'h10, 1'b1, 1'b1);
      issue(0, 4, 0, 5, 'h01, 1'b1, 1'b1);
      check("fwd first result", int'(ALUResult), 'h10);
      tick();
`ifdef FORWARD_EN
      fwd_exp = 'h11;
`else
      fwd_exp = 'h01;
`endif
      check("fwd out_valid", int'(out_valid), 1);
      check("fwd dependent result", int'(ALUResult), fwd_exp);

      // Writing OUT_REG updates cpu_out on the writeback edge
      issue(0, 0, 0, 15, 'h5A, 1'b1, 1'b1);
      check("cpu_out before wb", int'(cpu_out), 0);
      tick();
      check("cpu_out at wb", int'(cpu_out), 'h5A);

      // Reset mid-flight discards the operation; in_valid on the reset edge is ignored
      do_reset();
      check("cpu_out cleared", int'(cpu_out), 0);
      issue(0, 0, 0, 15, 'hAA, 1'b1, 1'b1);
      RST = 1'b1;
      in_valid = 1'b1;
      WA = 4'd15;
      immediate = 8'h33;
      tick();
      RST = 1'b0;
      in_valid = 1'b0;
      check("midflight cpu_out", int'(cpu_out), 0);
      check("midflight out_valid", int'(out_valid), 0);
      tick();
      check("reset-edge op ignored valid", int'(out_valid), 0);
      check("reset-edge op ignored cpu_out", int'(cpu_out), 0);

      // Randomized run against the reference model
      do_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 0;
      pv = 1'b0; pop = 0; pa = 0; pb = 0; pwa = 0; pwe = 1'b0;
      exp_pk = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         nv   = ($urandom_range(0, 9) < 7);
         nop  = $urandom_range(0, 7);
         nra1 = $urandom_range(0, NR - 1);
         nra2 = $urandom_range(0, NR - 1);
         nwa  = $urandom_range(0, NR - 1);
         nimm = $urandom_range(0, 255);
         nsrc = $urandom_range(0, 1);
         nwe  = ($urandom_range(0, 3) != 0);
         in_valid = nv; ALUControl = 3'(nop); RA1 = AW'(nra1); RA2 = AW'(nra2);
         WA = AW'(nwa); immediate = DW'(nimm); ALUSrc = nsrc; write_enable = nwe;

         a_old = m_regs[nra1];
         b_old = m_regs[nra2];
         exp_ov = pv ? 1 : 0;
         if (pv) begin
            exp_pk = alu_ref(pop, pa, pb);
            if (pwe) m_regs[pwa] = exp_pk >> 3;
         end
`ifdef FORWARD_EN
         a_old = m_regs[nra1];
         b_old = m_regs[nra2];
`endif
         pv = nv;
         if (nv) begin
            pop = nop; pa = a_old; pb = nsrc ? nimm : b_old; pwa = nwa; pwe = nwe;
         end
         tick();
         check("rand out_valid", int'(out_valid), exp_ov);
         check("rand result/flags", dut_pack(), exp_pk);
         check("rand cpu_out", int'(cpu_out), m_regs[NR - 1]);
      end
      in_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
